// File: rtl/fpu_pkg.sv
// Shared encodings for the FP sequencer: FSM state codes, precision select
// values and the operand width presented to the FPU.
package fpu_pkg;

  localparam int OP_W = 64;

  localparam logic FP_SINGLE = 1'b0;
  localparam logic FP_DOUBLE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_A_LO = 4'd1,
    ST_RD_A_HI = 4'd2,
    ST_RD_B_LO = 4'd3,
    ST_RD_B_HI = 4'd4,
    ST_EXEC    = 4'd5,
    ST_WB_LO   = 4'd6,
    ST_WB_HI   = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

endpackage

// File: rtl/fpu_seq.sv
// Multicycle sequencer around the combinational FP adder: fetches operands one
// word per cycle, holds them while the FPU settles, then writes the result back.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            double_in,
  input  logic [3:0]      rn,
  input  logic [3:0]      rm,
  input  logic [3:0]      rd,
  output logic [3:0]      rf_raddr,
  input  logic [31:0]     rf_rdata,
  output logic [OP_W-1:0] fpu_a,
  output logic [OP_W-1:0] fpu_b,
  output logic            fpu_double,
  input  logic [OP_W-1:0] fpu_result,
  output logic            rf_we,
  output logic [3:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            busy,
  output logic            done
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_t          state, nxt;
  logic [3:0]      rn_q, rm_q, rd_q;
  logic [CW-1:0]   exec_cnt;
  logic [OP_W-1:0] res_q;
  logic            exec_last;

  assign exec_last = (exec_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // fpu_double doubles as the latched precision for path selection
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:    if (start) nxt = ST_RD_A_LO;
      ST_RD_A_LO: nxt = fpu_double ? ST_RD_A_HI : ST_RD_B_LO;
      ST_RD_A_HI: nxt = ST_RD_B_LO;
      ST_RD_B_LO: nxt = fpu_double ? ST_RD_B_HI : ST_EXEC;
      ST_RD_B_HI: nxt = ST_EXEC;
      ST_EXEC:    if (exec_last) nxt = ST_WB_LO;
      ST_WB_LO:   nxt = fpu_double ? ST_WB_HI : ST_DONE;
      ST_WB_HI:   nxt = ST_DONE;
      ST_DONE:    nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_raddr = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    unique case (state)
      ST_RD_A_LO: rf_raddr = rn_q;
      ST_RD_A_HI: rf_raddr = rn_q + 4'd1;
      ST_RD_B_LO: rf_raddr = rm_q;
      ST_RD_B_HI: rf_raddr = rm_q + 4'd1;
      ST_WB_LO: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q;
        rf_wdata = res_q[31:0];
      end
      ST_WB_HI: begin
        rf_we    = 1'b1;
        rf_waddr = rd_q + 4'd1;
        rf_wdata = res_q[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rn_q       <= '0;
      rm_q       <= '0;
      rd_q       <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_double <= FP_SINGLE;
      exec_cnt   <= '0;
      res_q      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          rn_q       <= rn;
          rm_q       <= rm;
          rd_q       <= rd;
          fpu_double <= double_in ? FP_DOUBLE : FP_SINGLE;
          fpu_a      <= '0;
          fpu_b      <= '0;
        end
        ST_RD_A_LO: fpu_a[31:0]  <= rf_rdata;
        ST_RD_A_HI: fpu_a[63:32] <= rf_rdata;
        ST_RD_B_LO: begin
          fpu_b[31:0] <= rf_rdata;
          if (!fpu_double) exec_cnt <= CW'(EXEC_CYCLES - 1);
        end
        ST_RD_B_HI: begin
          fpu_b[63:32] <= rf_rdata;
          exec_cnt     <= CW'(EXEC_CYCLES - 1);
        end
        ST_EXEC: begin
          if (exec_last) res_q    <= fpu_result;
          else           exec_cnt <= exec_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
